mash111_ncn: RTL and testbench

MASH111_NCN -- requirements
Module: mash111_ncn

---
 rtl/mash111_ncn.sv | 100 ++++++++++
 tb/tb_mash111_ncn.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mash111_ncn.sv
`default_nettype none
// ============================================================================
// Module   : mash111_ncn
// Purpose  : MASH 1-1-1 noise-cancellation network; recombines three EFM
//            carries into a noise-shaped divide ratio for a fractional-N PLL.
// Revision : 1.0
// ============================================================================
module mash111_ncn #(
    parameter int P_INT_WIDTH = 8,
    parameter int P_DIV_WIDTH = P_INT_WIDTH + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [P_INT_WIDTH-1:0] i_int_n,
    input  logic                   i_q1,
    input  logic                   i_q2,
    input  logic                   i_q3,
    output logic signed [3:0]      o_frac,
    output logic [P_DIV_WIDTH-1:0] o_div,
    output logic                   o_valid,
    output logic                   o_clamp
);

    localparam int C_SUM_W = P_DIV_WIDTH + 1;

    logic              r_q1_d1;
    logic              r_q1_d2;
    logic              r_q2_d1;
    logic              r_q3_z1;
    logic signed [3:0] r_s2_z1;
    logic [1:0]        r_fill;

    logic signed [3:0] w_d3;
    logic signed [3:0] w_s2;
    logic signed [3:0] w_d2;
    logic signed [3:0] w_y;
    logic [C_SUM_W-1:0] w_sum;
    logic              w_neg;

    // Stage 1 lags two cycles and stage 2 one cycle so all carries line up
    // with the undelayed stage-3 carry.
    always_comb begin
        w_d3  = $signed({3'b000, i_q3}) - $signed({3'b000, r_q3_z1});
        w_s2  = $signed({3'b000, r_q2_d1}) + w_d3;
        w_d2  = w_s2 - r_s2_z1;
        w_y   = $signed({3'b000, r_q1_d2}) + w_d2;
        w_sum = C_SUM_W'(i_int_n) + {{(C_SUM_W-4){w_y[3]}}, w_y};
        w_neg = w_sum[C_SUM_W-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1_d1 <= 1'b0;
            r_q1_d2 <= 1'b0;
            r_q2_d1 <= 1'b0;
            r_q3_z1 <= 1'b0;
            r_s2_z1 <= '0;
            r_fill  <= '0;
            o_frac  <= '0;
            o_div   <= '0;
            o_valid <= 1'b0;
            o_clamp <= 1'b0;
        end else if (i_clr) begin
            r_q1_d1 <= 1'b0;
            r_q1_d2 <= 1'b0;
            r_q2_d1 <= 1'b0;
            r_q3_z1 <= 1'b0;
            r_s2_z1 <= '0;
            r_fill  <= '0;
            o_frac  <= '0;
            o_div   <= P_DIV_WIDTH'(i_int_n);
            o_valid <= 1'b0;
            o_clamp <= 1'b0;
        end else if (i_en) begin
            r_q1_d1 <= i_q1;
            r_q1_d2 <= r_q1_d1;
            r_q2_d1 <= i_q2;
            r_q3_z1 <= i_q3;
            r_s2_z1 <= w_s2;
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
            o_valid <= (r_fill == 2'd3);
            o_frac  <= w_y;
            // A negative ratio is meaningless to the divider; pin at zero and flag it.
            if (w_neg) begin
                o_div   <= '0;
                o_clamp <= 1'b1;
            end else begin
                o_div   <= w_sum[P_DIV_WIDTH-1:0];
            end
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mash111_ncn.sv
`default_nettype none
// ============================================================================
// Module   : tb_mash111_ncn
// Purpose  : Scoreboard bench for mash111_ncn against a history-based model.
// Revision : 1.0
// ============================================================================
module tb_mash111_ncn;

    localparam int IW = 8;
    localparam int DW = IW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en;
    logic              clr;
    logic [IW-1:0]     int_n;
    logic              q1;
    logic              q2;
    logic              q3;
    logic signed [3:0] frac;
    logic [DW-1:0]     div;
    logic              valid;
    logic              clamp;

    mash111_ncn #(.P_INT_WIDTH(IW), .P_DIV_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_clr   (clr),
        .i_int_n (int_n),
        .i_q1    (q1),
        .i_q2    (q2),
        .i_q3    (q3),
        .o_frac  (frac),
        .o_div   (div),
        .o_valid (valid),
        .o_clamp (clamp)
    );

    typedef struct {
        int frac;
        int div;
        int valid;
        int clamp;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Model: sample histories indexed by age in enabled edges (0 = this edge).
    int   h1[3];
    int   h2[3];
    int   h3[3];
    int   m_edges;
    exp_t m;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_hist();
        for (int i = 0; i < 3; i++) begin
            h1[i] = 0;
            h2[i] = 0;
            h3[i] = 0;
        end
        m_edges = 0;
    endtask

    task automatic model_step();
        int y;
        int t;
        if (!rst_n) begin
            model_clear_hist();
            m = '{0, 0, 0, 0};
        end else if (clr) begin
            model_clear_hist();
            m.frac  = 0;
            m.div   = int'(int_n);
            m.valid = 0;
            m.clamp = 0;
        end else if (en) begin
            for (int i = 2; i > 0; i--) begin
                h1[i] = h1[i-1];
                h2[i] = h2[i-1];
                h3[i] = h3[i-1];
            end
            h1[0] = int'(q1);
            h2[0] = int'(q2);
            h3[0] = int'(q3);
            y = h1[2] + h2[1] - h2[2] + h3[0] - 2 * h3[1] + h3[2];
            t = int'(int_n) + y;
            m.frac  = y;
            m.valid = (m_edges >= 3) ? 1 : 0;
            m_edges++;
            if (t < 0) begin
                m.div   = 0;
                m.clamp = 1;
            end else begin
                m.div = t;
            end
        end else begin
            m.valid = 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input int n,
                        input bit a, input bit b, input bit d);
        rst_n = r;
        en    = e;
        clr   = c;
        int_n = IW'(n);
        q1    = a;
        q2    = b;
        q3    = d;
        model_step();
        sbq.push_back(m);
        @(posedge clk);
        #3;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("frac",  int'(frac),  e.frac);
            check("div",   int'(div),   e.div);
            check("valid", int'(valid), e.valid);
            check("clamp", int'(clamp), e.clamp);
        end
    end

    initial begin
        int exp_f[4];
        int exp_d[4];
        int n;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; int_n = '0;
        q1 = 1'b0; q2 = 1'b0; q3 = 1'b0;
        model_clear_hist();
        m = '{0, 0, 0, 0};

        step(0, 0, 0, 100, 0, 0, 0);
        step(0, 1, 0, 100, 0, 0, 0);

        // Quiet input: ratio passes straight through, valid from 4th edge.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 100, 0, 0, 0);
            check("quiet_valid", int'(valid), (i >= 3) ? 1 : 0);
        end
        check("quiet_div", int'(div), 100);

        // Single stage-3 carry -> second-order difference impulse.
        exp_f = '{1, -2, 1, 0};
        exp_d = '{101, 98, 101, 100};
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 100, 0, 0, (i == 0));
            check("q3_pulse_frac", int'(frac), exp_f[i]);
            check("q3_pulse_div",  int'(div),  exp_d[i]);
        end

        // Single stage-1 carry emerges two edges later.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 100, (i == 0), 0, 0);
            check("q1_pulse_frac", int'(frac), (i == 2) ? 1 : 0);
        end

        // All carries held high, with a 5-cycle enable gap.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 100, 1, 1, 1);
        check("ones_frac", int'(frac), 1);
        check("ones_div",  int'(div),  101);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 100, 1, 1, 1);
            check("gap_valid", int'(valid), 0);
            check("gap_frac",  int'(frac),  1);
        end
        for (int i = 0; i < 4; i++) step(1, 1, 0, 100, 1, 1, 1);
        check("resume_frac",  int'(frac),  1);
        check("resume_valid", int'(valid), 1);

        // Clamp at zero with a small ratio, sticky until clear.
        step(1, 1, 1, 1, 0, 0, 0);
        exp_d = '{2, 0, 2, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 1, 0, 0, (i == 0));
            check("clamp_div",  int'(div),   exp_d[i]);
            check("clamp_flag", int'(clamp), (i >= 1) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 0);
        check("clamp_sticky", int'(clamp), 1);
        step(1, 1, 1, 1, 0, 0, 0);
        check("clr_clamp", int'(clamp), 0);
        check("clr_div",   int'(div),   1);
        check("clr_valid", int'(valid), 0);

        // Asynchronous reset while o_frac is -2.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 100, 0, 0, 0);
        step(1, 1, 0, 100, 0, 0, 1);
        step(1, 1, 0, 100, 0, 0, 0);
        check("pre_rst_frac", int'(frac), -2);
        rst_n = 1'b0;
        #1;
        check("arst_frac",  int'(frac),  0);
        check("arst_div",   int'(div),   0);
        check("arst_valid", int'(valid), 0);
        check("arst_clamp", int'(clamp), 0);
        step(0, 1, 0, 100, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 100, 0, 0, 0);
            check("post_rst_valid", int'(valid), (i >= 3) ? 1 : 0);
        end

        // Randomized traffic, including clamps, clears, gaps and resets.
        for (int i = 0; i < 600; i++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 39) == 0),
                 n,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
